// File: rtl/pipelined_cla_adder_pkg.sv
// rtl/pipelined_cla_adder_pkg.sv - shared constants for the pipelined CLA adder
//
// Purpose : lookahead block width, add/sub mode encodings and the stage-count
//           formula shared by the adder top and its 4-bit lookahead block.
// Ports   : none (package).

`ifndef PIPELINED_CLA_ADDER_PKG_SV
`define PIPELINED_CLA_ADDER_PKG_SV

// Number of pipeline stages for a given width and blocks-per-stage.
`define PCLA_NUM_STAGES(w, bps) ((w) / (CLA_BLOCK_W * (bps)))

package pipelined_cla_adder_pkg;

    localparam int CLA_BLOCK_W = 4;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

`endif

// File: rtl/pipelined_cla_adder_cla_block_4bit.sv
// rtl/pipelined_cla_adder_cla_block_4bit.sv - combinational 4-bit carry-lookahead block
//
// Purpose : resolves one 4-bit slice with full internal lookahead and exports
//           group propagate/generate so blocks can be chained by P/G.
// Ports   : a, b   - 4-bit operand slices
//           cin    - carry into bit 0 of the slice
//           sum    - 4-bit slice result
//           cout   - carry out of bit 3
//           grp_p  - group propagate (all four bits propagate)
//           grp_g  - group generate (slice produces a carry on its own)

module cla_block_4bit
    import pipelined_cla_adder_pkg::*;
(
    input  logic [CLA_BLOCK_W-1:0] a,
    input  logic [CLA_BLOCK_W-1:0] b,
    input  logic                   cin,
    output logic [CLA_BLOCK_W-1:0] sum,
    output logic                   cout,
    output logic                   grp_p,
    output logic                   grp_g
);

    logic [CLA_BLOCK_W-1:0] p;
    logic [CLA_BLOCK_W-1:0] g;
    logic                   c1;
    logic                   c2;
    logic                   c3;

    assign p = a ^ b;
    assign g = a & b;

    // Every carry is a flat sum of products of p/g and cin: no ripple inside.
    assign c1 = g[0] | (p[0] & cin);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

    assign grp_p = &p;
    assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);

    assign cout = grp_g | (grp_p & cin);
    assign sum  = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - pipelined carry-lookahead adder/subtractor with valid/ready
//
// Purpose : WIDTH-bit a+b+cin or a-b, one slice of 4*BLOCKS_PER_STAGE bits per
//           pipeline stage, one result per cycle, NUM_STAGES cycles of latency.
// Ports   : clk, rst           - clock, synchronous active-high reset
//           in_valid/in_ready  - operand handshake
//           a, b, cin, sub     - operands, carry in (ignored for sub), mode
//           out_valid/out_ready- result handshake
//           sum, cout, overflow- result, carry out of MSB, signed overflow

module pipelined_cla_adder
    import pipelined_cla_adder_pkg::*;
#(
    parameter int WIDTH            = 32,
    parameter int BLOCKS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int S          = CLA_BLOCK_W * BLOCKS_PER_STAGE;
    localparam int NUM_STAGES = `PCLA_NUM_STAGES(WIDTH, BLOCKS_PER_STAGE);

    if (((WIDTH % S) != 0) || (WIDTH < S)) begin : g_param_check
        $error("pipelined_cla_adder: WIDTH must be a non-zero multiple of 4*BLOCKS_PER_STAGE");
    end

    // One enable for the whole pipe: everything moves unless the output is
    // holding a result nobody has taken yet.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        // Operand bits still unresolved when entering stage k; the low S of
        // them are resolved here, the rest ride on to the next stage.
        localparam int REM = WIDTH - k * S;

        logic [REM-1:0]              a_in;
        logic [REM-1:0]              b_in;
        logic                        c_in;
        logic                        v_in;
        logic [BLOCKS_PER_STAGE:0]   blk_c;
        logic [BLOCKS_PER_STAGE-1:0] blk_p;
        logic [BLOCKS_PER_STAGE-1:0] blk_g;
        logic [BLOCKS_PER_STAGE-1:0] blk_co;
        logic [S-1:0]                slice_sum;
        logic [(k+1)*S-1:0]          s_d;
        logic [(k+1)*S-1:0]          s_q;
        logic                        c_q;
        logic                        v_q;
        logic                        unused_blk_co;

        if (k == 0) begin : g_head
            // Subtraction is a + ~b + 1, so the mode only touches b and c0.
            assign a_in = a;
            assign b_in = (sub == MODE_ADD) ? b : ~b;
            assign c_in = (sub == MODE_SUB) ? 1'b1 : cin;
            assign v_in = in_valid;
            assign s_d  = slice_sum;
        end else begin : g_body
            assign a_in = g_stage[k-1].g_ops.a_q;
            assign b_in = g_stage[k-1].g_ops.b_q;
            assign c_in = g_stage[k-1].c_q;
            assign v_in = g_stage[k-1].v_q;
            // Lower result slices travel with the op so the word lines up.
            assign s_d  = {slice_sum, g_stage[k-1].s_q};
        end

        assign blk_c[0] = c_in;

        for (genvar j = 0; j < BLOCKS_PER_STAGE; j++) begin : g_blk
            cla_block_4bit u_blk (
                .a     (a_in[j*CLA_BLOCK_W +: CLA_BLOCK_W]),
                .b     (b_in[j*CLA_BLOCK_W +: CLA_BLOCK_W]),
                .cin   (blk_c[j]),
                .sum   (slice_sum[j*CLA_BLOCK_W +: CLA_BLOCK_W]),
                .cout  (blk_co[j]),
                .grp_p (blk_p[j]),
                .grp_g (blk_g[j])
            );
            assign blk_c[j+1] = blk_g[j] | (blk_p[j] & blk_c[j]);
        end

        // Block cout equals the group P/G carry already used above.
        assign unused_blk_co = ^blk_co;

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= v_in;
                // Bubbles leave the data registers alone, so the final stage
                // keeps showing the last real result while out_valid is 0.
                if (v_in) begin
                    c_q <= blk_c[BLOCKS_PER_STAGE];
                    s_q <= s_d;
                end
            end
        end

        if (k < NUM_STAGES - 1) begin : g_ops
            logic [REM-S-1:0] a_q;
            logic [REM-S-1:0] b_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv && v_in) begin
                    a_q <= a_in[REM-1:S];
                    b_q <= b_in[REM-1:S];
                end
            end
        end else begin : g_tail
            logic msb_c;
            logic ovf_q;

            // Carry into the MSB recovered from its sum bit: s = a ^ b ^ c.
            assign msb_c = slice_sum[S-1] ^ a_in[S-1] ^ b_in[S-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv && v_in) begin
                    ovf_q <= msb_c ^ blk_c[BLOCKS_PER_STAGE];
                end
            end
        end
    end

    assign out_valid = g_stage[NUM_STAGES-1].v_q;
    assign sum       = g_stage[NUM_STAGES-1].s_q;
    assign cout      = g_stage[NUM_STAGES-1].c_q;
    assign overflow  = g_stage[NUM_STAGES-1].g_tail.ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb/tb_pipelined_cla_adder.sv - self-checking bench for pipelined_cla_adder

module tb_pipelined_cla_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid  [2];
    logic        out_ready [2];
    logic        cin       [2];
    logic        sub       [2];
    logic [31:0] a         [2];
    logic [31:0] b         [2];
    logic        in_ready  [2];
    logic        out_valid [2];
    logic        cout      [2];
    logic        ovf       [2];
    logic [31:0] sum       [2];
    logic [15:0] sum16;

    assign sum[0] = {16'h0000, sum16};

    // d=0: 16-bit, one block per stage (4 stages)
    pipelined_cla_adder #(.WIDTH(16), .BLOCKS_PER_STAGE(1)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[0][15:0]), .b(b[0][15:0]), .cin(cin[0]), .sub(sub[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .sum(sum16), .cout(cout[0]), .overflow(ovf[0])
    );

    // d=1: 32-bit, two blocks per stage (4 stages)
    pipelined_cla_adder #(.WIDTH(32), .BLOCKS_PER_STAGE(2)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[1]), .b(b[1]), .cin(cin[1]), .sub(sub[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .sum(sum[1]), .cout(cout[1]), .overflow(ovf[1])
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [33:0] q0[$];
    logic [33:0] q1[$];
    int          pops         [2];
    int          last_out_cyc [2];
    logic        stall_prev   [2];
    logic [33:0] prev_out     [2];

    // Golden result {overflow, cout, sum} from plain integer arithmetic.
    function automatic logic [33:0] model(input int w, input logic [31:0] av,
                                          input logic [31:0] bv, input logic ci,
                                          input logic sb);
        logic [31:0] mask;
        logic [31:0] am;
        logic [31:0] bm;
        logic [31:0] s;
        logic [32:0] full;
        logic        co;
        logic        ov;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        am   = av & mask;
        bm   = (sb ? ~bv : bv) & mask;
        full = {1'b0, am} + {1'b0, bm} + {32'h0, (sb ? 1'b1 : ci)};
        s    = full[31:0] & mask;
        co   = full[w];
        if (sb) ov = (av[w-1] != bv[w-1]) && (s[w-1] != av[w-1]);
        else    ov = (av[w-1] == bv[w-1]) && (s[w-1] != av[w-1]);
        return {ov, co, s};
    endfunction

    task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic eval_dut(input int d);
        logic [33:0] e;
        logic [33:0] cur;
        int          sz;
        cur = {ovf[d], cout[d], sum[d]};
        if (!rst)
            check($sformatf("in_ready_d%0d", d), 34'(in_ready[d]),
                  34'(!out_valid[d] || out_ready[d]));
        if (stall_prev[d]) begin
            check($sformatf("hold_valid_d%0d", d), 34'(out_valid[d]), 34'd1);
            check($sformatf("hold_data_d%0d", d), cur, prev_out[d]);
        end
        if (rst) begin
            if (d == 0) q0.delete(); else q1.delete();
        end else begin
            if (out_valid[d] && out_ready[d]) begin
                sz = (d == 0) ? q0.size() : q1.size();
                check($sformatf("expected_pending_d%0d", d), 34'(sz != 0), 34'd1);
                if (sz != 0) begin
                    if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
                    check($sformatf("result_d%0d", d), cur, e);
                    pops[d]++;
                    last_out_cyc[d] = cyc;
                end
            end
            if (in_valid[d] && in_ready[d]) begin
                e = model((d == 0) ? 16 : 32, a[d], b[d], cin[d], sub[d]);
                if (d == 0) q0.push_back(e); else q1.push_back(e);
            end
        end
        stall_prev[d] = !rst && out_valid[d] && !out_ready[d];
        prev_out[d]   = cur;
    endtask

    // Inputs are set at the falling edge; checks run 1 time unit later.
    task automatic tick();
        #1;
        eval_dut(0);
        eval_dut(1);
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drive(input int d, input logic [31:0] av, input logic [31:0] bv,
                         input logic ci, input logic sb);
        in_valid[d] = 1'b1;
        a[d]        = av;
        b[d]        = bv;
        cin[d]      = ci;
        sub[d]      = sb;
    endtask

    task automatic check_reset_state(input int d);
        check($sformatf("rst_out_valid_d%0d", d), 34'(out_valid[d]), 34'd0);
        check($sformatf("rst_result_d%0d", d), {ovf[d], cout[d], sum[d]}, 34'd0);
        check($sformatf("rst_in_ready_d%0d", d), 34'(in_ready[d]), 34'd1);
    endtask

    initial begin
        int p;
        int issue;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0; out_ready[d] = 1'b1; cin[d] = 1'b0; sub[d] = 1'b0;
            a[d] = '0; b[d] = '0;
            pops[d] = 0; last_out_cyc[d] = -1; stall_prev[d] = 1'b0; prev_out[d] = '0;
        end
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_reset_state(0);
        check_reset_state(1);

        // Carry ripples through every slice; latency must be exactly 4.
        drive(0, 32'hFFFF, 32'h0001, 1'b0, 1'b0);
        issue = cyc;
        p = pops[0];
        tick();
        in_valid[0] = 1'b0;
        for (int i = 0; i < 10 && pops[0] == p; i++) tick();
        check("latency_d0", 34'(last_out_cyc[0] - issue), 34'd4);

        // Signed overflow add, overflow subtract, borrow subtract (cin ignored).
        drive(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0); tick();
        drive(0, 32'h8000, 32'h0001, 1'b0, 1'b1); tick();
        drive(0, 32'h0005, 32'h0007, 1'b1, 1'b1); tick();
        in_valid[0] = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        // Eight back-to-back operations at full rate.
        p = pops[0];
        issue = cyc;
        for (int i = 0; i < 8; i++) begin
            drive(0, 32'h1111 * i + 32'h0101, 32'h0F0F * i, i[0], 1'b0);
            #1;
            check("b2b_in_ready", 34'(in_ready[0]), 34'd1);
            tick();
        end
        in_valid[0] = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("b2b_count", 34'(pops[0] - p), 34'd8);
        check("b2b_last_cycle", 34'(last_out_cyc[0] - issue), 34'd11);

        // Backpressure: hold five cycles once the first result is presented.
        p = pops[0];
        for (int i = 0; i < 4; i++) begin
            drive(0, 32'h2345 * (i + 1), 32'h1F00 + i, 1'b1, i[1]);
            tick();
        end
        out_ready[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(0, 32'hDEAD, 32'hBEEF, 1'b0, 1'b0);
            #1;
            check("bp_out_valid", 34'(out_valid[0]), 34'd1);
            check("bp_in_ready", 34'(in_ready[0]), 34'd0);
            tick();
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("bp_drain_count", 34'(pops[0] - p), 34'd4);

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) begin
            drive(0, 32'h0F0F + i, 32'h7070, 1'b0, 1'b0);
            tick();
        end
        in_valid[0] = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        p = pops[0];
        #1;
        check("midrst_out_valid", 34'(out_valid[0]), 34'd0);
        check("midrst_sum", 34'(sum[0]), 34'd0);
        for (int i = 0; i < 8; i++) tick();
        check("midrst_no_stale", 34'(pops[0] - p), 34'd0);

        // Random traffic with random backpressure on both configurations.
        for (int i = 0; i < 10000; i++) begin
            for (int d = 0; d < 2; d++) begin
                in_valid[d]  = ($urandom_range(0, 3) != 0);
                out_ready[d] = ($urandom_range(0, 3) != 0);
                a[d]   = $urandom;
                b[d]   = $urandom;
                cin[d] = $urandom_range(0, 1) == 1;
                sub[d] = $urandom_range(0, 1) == 1;
                case ($urandom_range(0, 15))
                    0: a[d] = 32'hFFFF_FFFF;
                    1: b[d] = 32'hFFFF_FFFF;
                    2: begin a[d] = 32'h7FFF_7FFF; b[d] = 32'h0000_0001; end
                    3: b[d] = a[d];
                    default: ;
                endcase
            end
            tick();
        end
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
        end
        for (int i = 0; i < 20; i++) tick();
        check("drain_empty_d0", 34'(q0.size()), 34'd0);
        check("drain_empty_d1", 34'(q1.size()), 34'd0);
        check("random_activity_d1", 34'(pops[1] > 1000), 34'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
